// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I decode stage: ALU op codes, opcodes,
// the decoded bundle and immediate extraction helpers.
package alu_pkg;

  // ALU operation codes consumed by the execute stage
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_SRA  = 4'd13;
  localparam logic [3:0] ALU_SLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct7 values: base encoding and the sub/sra alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic        shamt_from_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;
  } decode_bundle_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/alu_decode_stage_alu_op_decode.sv
// Combinational RV32I decoder: instruction word -> decoded ALU bundle.
// Unsupported encodings collapse to an all-zero bundle with illegal=1.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decode_bundle_t bundle_o
);

  logic [6:0]     opcode;
  logic [6:0]     funct7;
  logic [2:0]     funct3;
  logic           bad;
  decode_bundle_t b;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Per-format field selection; fields a format does not use stay zero
  always_comb begin
    b   = '0;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        b.rs1       = instr_i[19:15];
        b.rs2       = instr_i[24:20];
        b.rd        = instr_i[11:7];
        b.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: b.alu_op = ALU_ADD;
            3'b001: begin b.alu_op = ALU_SLL; b.shamt_from_reg = 1'b1; end
            3'b010: b.alu_op = ALU_SLT;
            3'b011: b.alu_op = ALU_SLTU;
            3'b100: b.alu_op = ALU_XOR;
            3'b101: begin b.alu_op = ALU_SRL; b.shamt_from_reg = 1'b1; end
            3'b110: b.alu_op = ALU_OR;
            default: b.alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          b.alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          b.alu_op         = ALU_SRA;
          b.shamt_from_reg = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        b.rs1       = instr_i[19:15];
        b.rd        = instr_i[11:7];
        b.reg_write = 1'b1;
        b.use_imm   = 1'b1;
        b.imm       = imm_i(instr_i);
        case (funct3)
          3'b000: b.alu_op = ALU_ADD;
          3'b010: b.alu_op = ALU_SLT;
          3'b011: b.alu_op = ALU_SLTU;
          3'b100: b.alu_op = ALU_XOR;
          3'b110: b.alu_op = ALU_OR;
          3'b111: b.alu_op = ALU_AND;
          3'b001: begin
            // Shift immediates carry only the 5-bit amount
            b.alu_op = ALU_SLL;
            b.shamt  = instr_i[24:20];
            b.imm    = {27'b0, instr_i[24:20]};
            bad      = (funct7 != F7_BASE);
          end
          default: begin
            b.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            b.shamt  = instr_i[24:20];
            b.imm    = {27'b0, instr_i[24:20]};
            bad      = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_BRANCH: begin
        b.rs1       = instr_i[19:15];
        b.rs2       = instr_i[24:20];
        b.is_branch = 1'b1;
        b.imm       = imm_b(instr_i);
        case (funct3)
          3'b000: b.alu_op = ALU_EQ;
          3'b001: b.alu_op = ALU_NE;
          3'b100: b.alu_op = ALU_SLT;
          3'b101: b.alu_op = ALU_GE;
          3'b110: b.alu_op = ALU_SLTU;
          3'b111: b.alu_op = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        b.rs1       = instr_i[19:15];
        b.rd        = instr_i[11:7];
        b.imm       = imm_i(instr_i);
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
        b.alu_op    = ALU_ADD;
        bad         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        b.rs1     = instr_i[19:15];
        b.rs2     = instr_i[24:20];
        b.imm     = imm_s(instr_i);
        b.use_imm = 1'b1;
        b.alu_op  = ALU_ADD;
        bad       = (funct3 > 3'b010);
      end
      OPC_LUI, OPC_AUIPC: begin
        b.rd        = instr_i[11:7];
        b.imm       = imm_u(instr_i);
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
        b.alu_op    = ALU_ADD;
      end
      OPC_JAL: begin
        b.rd        = instr_i[11:7];
        b.imm       = imm_j(instr_i);
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
        b.alu_op    = ALU_ADD;
      end
      OPC_JALR: begin
        b.rs1       = instr_i[19:15];
        b.rd        = instr_i[11:7];
        b.imm       = imm_i(instr_i);
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
        b.alu_op    = ALU_ADD;
        bad         = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      b         = '0;
      b.illegal = 1'b1;
    end
  end

  assign bundle_o = b;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready on
// both sides and a flush for redirects.
// Build option DECODE_SKID_EN: two-entry skid buffer with a registered
// in_ready; otherwise a single output register whose in_ready is
// combinational from out_ready.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [4:0]  shamt,
  output logic        shamt_from_reg,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        reg_write,
  output logic        is_branch,
  output logic        illegal
);

  decode_bundle_t dec_bundle;
  decode_bundle_t main_q, main_d;
  decode_bundle_t out_bundle;
  logic           main_valid_q, main_valid_d;

  alu_op_decode u_decode (
    .instr_i  (instr),
    .bundle_o (dec_bundle)
  );

`ifdef DECODE_SKID_EN
  decode_bundle_t skid_q, skid_d;
  logic           skid_valid_q, skid_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           accept, pop;

  assign accept   = in_valid & in_ready_q;
  assign pop      = main_valid_q & out_ready;
  assign in_ready = in_ready_q;

  // Next state: refill main from skid first, park arrivals in skid on stall
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_bundle;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_bundle;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers for main entry, skid entry and registered in_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !main_valid_q | out_ready;

  // Next state: load on accept, empty on transfer, flush wins over both
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      main_d       = dec_bundle;
      main_valid_d = 1'b1;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  // Single output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end
`endif

  // Bundle outputs read as zero whenever nothing valid is presented
  assign out_bundle     = main_valid_q ? main_q : '0;
  assign out_valid      = main_valid_q;
  assign alu_op         = out_bundle.alu_op;
  assign shamt          = out_bundle.shamt;
  assign shamt_from_reg = out_bundle.shamt_from_reg;
  assign rs1            = out_bundle.rs1;
  assign rs2            = out_bundle.rs2;
  assign rd             = out_bundle.rd;
  assign imm            = out_bundle.imm;
  assign use_imm        = out_bundle.use_imm;
  assign reg_write      = out_bundle.reg_write;
  assign is_branch      = out_bundle.is_branch;
  assign illegal        = out_bundle.illegal;

endmodule
